if_fetch: RTL and testbench

Instruction-fetch stage for the 16-bit pipelined CPU. Holds the PC, runs a request/acknowledge handshake with instruction memory, and loads the IF/ID pipeline register that feeds the decode stage. The decode stage consumes `inst_o`/`pc_o` and returns the branch decision. The block tolerates variable memory latency, pipeline stalls and one architectural branch delay slot.

---
 rtl/if_fetch.sv | 120 ++++++++++++
 tb/tb_if_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// loads the IF/ID register, with a one-entry hold buffer and one branch delay slot.
module if_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [15:0] branch_addr_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] inst_o,
    output logic [15:0] pc_o,
    output logic        inst_valid_o,
    output logic        stall_req_o
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] buf_inst_q, buf_inst_d;
    logic        redir_pend_q, redir_pend_d;
    logic [15:0] redir_addr_q, redir_addr_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    logic        branch_taken;
    logic [15:0] pc_inc;
    logic [15:0] next_pc;

    // A branch only counts when decode holds a real instruction and is not frozen.
    assign branch_taken = branch_flag_i && valid_q && !stall_i;
    assign pc_inc       = pc_q + 16'd1;
    assign next_pc      = branch_taken ? branch_addr_i :
                          redir_pend_q ? redir_addr_q  : pc_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            buf_inst_q   <= NOP_INST;
            redir_pend_q <= 1'b0;
            redir_addr_q <= 16'h0000;
            inst_q       <= NOP_INST;
            pc_out_q     <= 16'h0000;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_inst_q   <= buf_inst_d;
            redir_pend_q <= redir_pend_d;
            redir_addr_q <= redir_addr_d;
            inst_q       <= inst_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_inst_d   = buf_inst_q;
        redir_pend_d = redir_pend_q;
        redir_addr_d = redir_addr_q;
        inst_d       = inst_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;

        case (state_q)
            FETCH: begin
                if (imem_ack_i && !stall_i) begin
                    inst_d       = imem_rdata_i;
                    pc_out_d     = pc_inc;
                    valid_d      = 1'b1;
                    pc_d         = next_pc;
                    redir_pend_d = 1'b0;
                end else if (imem_ack_i) begin
                    buf_inst_d = imem_rdata_i;
                    state_d    = HOLD;
                end else if (!stall_i) begin
                    // Bubble; a branch seen now must wait for the delay slot to arrive.
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    if (branch_taken) begin
                        redir_pend_d = 1'b1;
                        redir_addr_d = branch_addr_i;
                    end
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    inst_d       = buf_inst_q;
                    pc_out_d     = pc_inc;
                    valid_d      = 1'b1;
                    pc_d         = next_pc;
                    redir_pend_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_req_o   = (state_q == FETCH) && !rst;
    assign imem_addr_o  = pc_q;
    assign stall_req_o  = (state_q == FETCH) && !imem_ack_i && !rst;
    assign inst_o       = inst_q;
    assign pc_o         = pc_out_q;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: expected fetch addresses and IF/ID deliveries
// are queued as stimulus is applied and compared as the stage produces them.
module tb_if_fetch;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [15:0] branch_addr_i = 16'h0000;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [15:0] imem_rdata_i = 16'h0000;
    logic [15:0] inst_o;
    logic [15:0] pc_o;
    logic        inst_valid_o;
    logic        stall_req_o;

    int checks = 0;
    int failures = 0;

    logic [15:0] expAddrQ[$];
    logic [31:0] deliverQ[$];
    logic        held = 1'b0;
    logic [15:0] lastInst = NOP;
    logic [15:0] lastPc = 16'h0000;
    logic        lastValid = 1'b0;

    if_fetch #(
        .RESET_PC(16'h0000),
        .NOP_INST(NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .branch_flag_i(branch_flag_i),
        .branch_addr_i(branch_addr_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .inst_valid_o (inst_valid_o),
        .stall_req_o  (stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock: drive at the falling edge, check combinational outputs, then
    // advance the IF/ID expectation and compare just after the rising edge.
    task automatic applyStimulus(input logic stall, input logic ackEn,
                                 input logic bflag, input logic [15:0] baddr);
        logic        accepted;
        logic        expReq;
        logic [15:0] a;
        logic [31:0] d;
        @(negedge clk);
        stall_i       = stall;
        branch_flag_i = bflag;
        branch_addr_i = baddr;
        imem_ack_i    = ackEn;
        imem_rdata_i  = imem_addr_o | 16'h4000;
        accepted      = ackEn && !rst && !held;
        expReq        = !rst && !held;
        #1;
        checkOutput("imem_req", 16'(imem_req_o), 16'(expReq));
        checkOutput("stall_req", 16'(stall_req_o), 16'(expReq && !ackEn));
        if (expReq) begin
            checkOutput("addr_q_nonempty", 16'(expAddrQ.size() != 0), 16'd1);
            if (expAddrQ.size() != 0) checkOutput("imem_addr", imem_addr_o, expAddrQ[0]);
        end
        if (accepted && expAddrQ.size() != 0) begin
            a = expAddrQ.pop_front();
            deliverQ.push_back({a | 16'h4000, a + 16'd1});
        end
        @(posedge clk);
        #1;
        if (rst) begin
            lastInst  = NOP;
            lastPc    = 16'h0000;
            lastValid = 1'b0;
            held      = 1'b0;
            deliverQ.delete();
            expAddrQ.delete();
        end else if (!stall) begin
            if (held || accepted) begin
                checkOutput("deliver_q_nonempty", 16'(deliverQ.size() != 0), 16'd1);
                if (deliverQ.size() != 0) begin
                    d         = deliverQ.pop_front();
                    lastInst  = d[31:16];
                    lastPc    = d[15:0];
                    lastValid = 1'b1;
                end
                held = 1'b0;
            end else begin
                lastInst  = NOP;
                lastValid = 1'b0;
            end
        end else if (accepted) begin
            held = 1'b1;
        end
        checkOutput("inst_o", inst_o, lastInst);
        checkOutput("pc_o", pc_o, lastPc);
        checkOutput("inst_valid", 16'(inst_valid_o), 16'(lastValid));
    endtask

    task automatic resetDut(input int n);
        rst = 1'b1;
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
    endtask

    task automatic pushAddrRange(input logic [15:0] first, input int count);
        for (int i = 0; i < count; i++) expAddrQ.push_back(first + 16'(i));
    endtask

    initial begin
        // Stream from reset, two wait cycles at 3, branch to 0x20 with the delay slot acked.
        resetDut(2);
        pushAddrRange(16'h0000, 6);
        pushAddrRange(16'h0020, 2);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("s1_addr_drain", 16'(expAddrQ.size()), 16'd0);

        // Branch to 0x40 taken while the fetch of 7 is still waiting.
        resetDut(2);
        pushAddrRange(16'h0000, 8);
        pushAddrRange(16'h0040, 2);
        repeat (7) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0040);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("s2_addr_drain", 16'(expAddrQ.size()), 16'd0);

        // Stall for three cycles from the ack of 9; a branch under stall is ignored.
        resetDut(2);
        pushAddrRange(16'h0000, 12);
        repeat (9) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0077);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("s3_addr_drain", 16'(expAddrQ.size()), 16'd0);

        // Reset while a fetch is waiting and memory acks in the reset cycle.
        resetDut(2);
        pushAddrRange(16'h0000, 3);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        rst = 1'b0;
        pushAddrRange(16'h0000, 2);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("s4_addr_drain", 16'(expAddrQ.size()), 16'd0);

        // PC wrap: branch to 0xFFFF, then the sequential fetch wraps to 0.
        resetDut(2);
        pushAddrRange(16'h0000, 2);
        expAddrQ.push_back(16'hFFFF);
        expAddrQ.push_back(16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("s5_addr_drain", 16'(expAddrQ.size()), 16'd0);
        checkOutput("deliver_drain", 16'(deliverQ.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
